// File: rtl/signed_seg_display_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | signed_seg_display_ctrl_if : value handshake and display pin bundle        |
// | Rev 1.0 - SEG_BRIGHTNESS_EN adds the BRIGHTNESS input                      |
// +----------------------------------------------------------------------------+
interface signed_seg_display_ctrl_if #(
  parameter int INPUT_W    = 25,
  parameter int NUM_DIGITS = 8
);
  logic [INPUT_W-1:0]            VALUE_IN;
  logic                          DP_EN;
  logic [$clog2(NUM_DIGITS)-1:0] DP_POS;
  logic                          VALUE_VALID;
  logic                          VALUE_READY;
  logic                          OVERFLOW;
  logic [7:0]                    segment;
  logic [NUM_DIGITS-1:0]         anode;
`ifdef SEG_BRIGHTNESS_EN
  logic [2:0]                    BRIGHTNESS;

  modport master (output VALUE_IN, DP_EN, DP_POS, VALUE_VALID, BRIGHTNESS,
                  input  VALUE_READY, OVERFLOW, segment, anode);
  modport slave  (input  VALUE_IN, DP_EN, DP_POS, VALUE_VALID, BRIGHTNESS,
                  output VALUE_READY, OVERFLOW, segment, anode);
`else
  modport master (output VALUE_IN, DP_EN, DP_POS, VALUE_VALID,
                  input  VALUE_READY, OVERFLOW, segment, anode);
  modport slave  (input  VALUE_IN, DP_EN, DP_POS, VALUE_VALID,
                  output VALUE_READY, OVERFLOW, segment, anode);
`endif
endinterface
`default_nettype wire

// File: rtl/signed_seg_display_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | signed_seg_display_ctrl : signed value -> BCD -> multiplexed 7-seg driver  |
// | Rev 1.0 - optional SEG_BRIGHTNESS_EN gates anode duty cycle                |
// +----------------------------------------------------------------------------+
module signed_seg_display_ctrl #(
  parameter int INPUT_W         = 25,
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  signed_seg_display_ctrl_if.slave  bus
);
  localparam int c_IW = $clog2(NUM_DIGITS);
  localparam int c_TW = $clog2(TICKS_PER_DIGIT);
  localparam int c_CW = $clog2(INPUT_W + 1);
  localparam int c_BW = 4 * (NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_ready;
  logic [INPUT_W-1:0]  r_mag;
  logic                r_sign, r_dp_en, r_ovf;
  logic [c_IW-1:0]     r_dp_pos;
  logic [c_BW-1:0]     r_bcd, w_adj;
  logic [c_CW-1:0]     r_cnt;
  logic [c_BW-1:0]     r_disp_bcd;
  logic                r_disp_sign, r_disp_dp_en, r_disp_ovf;
  logic [c_IW-1:0]     r_disp_dp_pos;
  logic [c_TW-1:0]     r_tick, w_tick_next;
  logic [c_IW-1:0]     r_idx, w_idx_next, w_hz;
  logic [7:0]          r_seg, w_seg_next;
  logic [NUM_DIGITS-1:0] r_an, w_an_next;
  logic                w_accept, w_tick_wrap, w_dp_eff, w_lit;
  logic [INPUT_W-1:0]  w_abs;
  logic [4*NUM_DIGITS-1:0] w_bcd_ext;
  logic [3:0]          w_nib;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 8'h03; 4'd1: seg7 = 8'h9F; 4'd2: seg7 = 8'h25; 4'd3: seg7 = 8'h0D;
      4'd4: seg7 = 8'h99; 4'd5: seg7 = 8'h49; 4'd6: seg7 = 8'h41; 4'd7: seg7 = 8'h1F;
      4'd8: seg7 = 8'h01; 4'd9: seg7 = 8'h09; default: seg7 = 8'hFF;
    endcase
  endfunction

  assign w_accept = bus.VALUE_VALID && r_ready;
  assign w_abs    = bus.VALUE_IN[INPUT_W-1] ? (~bus.VALUE_IN + 1'b1) : bus.VALUE_IN;

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_next = ST_CONVERT;
      ST_CONVERT: if (r_cnt == c_CW'(INPUT_W - 1)) w_state_next = ST_COMMIT;
      ST_COMMIT:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Double-dabble correction step: nibbles >= 5 would exceed 9 after the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS - 1; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_ready       <= 1'b0;
      r_mag         <= '0;
      r_sign        <= 1'b0;
      r_dp_en       <= 1'b0;
      r_dp_pos      <= '0;
      r_bcd         <= '0;
      r_ovf         <= 1'b0;
      r_cnt         <= '0;
      r_disp_bcd    <= '0;
      r_disp_sign   <= 1'b0;
      r_disp_dp_en  <= 1'b0;
      r_disp_dp_pos <= '0;
      r_disp_ovf    <= 1'b0;
    end else begin
      r_ready <= (w_state_next == ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_sign   <= bus.VALUE_IN[INPUT_W-1];
          r_mag    <= w_abs;
          r_dp_en  <= bus.DP_EN;
          r_dp_pos <= bus.DP_POS;
          r_bcd    <= '0;
          r_ovf    <= 1'b0;
          r_cnt    <= '0;
        end
        ST_CONVERT: begin
          r_bcd <= {w_adj[c_BW-2:0], r_mag[INPUT_W-1]};
          r_ovf <= r_ovf | w_adj[c_BW-1];
          r_mag <= {r_mag[INPUT_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        ST_COMMIT: begin
          r_disp_bcd    <= r_bcd;
          r_disp_sign   <= r_sign;
          r_disp_dp_en  <= r_dp_en;
          r_disp_dp_pos <= r_dp_pos;
          r_disp_ovf    <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  assign w_tick_wrap = (r_tick == c_TW'(TICKS_PER_DIGIT - 1));
  assign w_tick_next = w_tick_wrap ? '0 : r_tick + 1'b1;
  assign w_idx_next  = !w_tick_wrap ? r_idx :
                       (r_idx == c_IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
  assign w_bcd_ext   = {4'd0, r_disp_bcd};
  assign w_nib       = w_bcd_ext[{w_idx_next, 2'b00} +: 4];

  // Pattern is built from the next index so segment and anode switch together
  always_comb begin
    w_hz = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++)
      if (r_disp_bcd[4*i +: 4] != 4'd0) w_hz = c_IW'(i);
    w_dp_eff = r_disp_dp_en && (r_disp_dp_pos != '0) &&
               (r_disp_dp_pos <= c_IW'(NUM_DIGITS - 2));
    w_seg_next = seg7(w_nib);
    if ((w_idx_next > w_hz) && !(w_dp_eff && (w_idx_next <= r_disp_dp_pos)))
      w_seg_next = 8'hFF;
    if (w_dp_eff && (w_idx_next == r_disp_dp_pos)) w_seg_next[0] = 1'b0;
    if (w_idx_next == c_IW'(NUM_DIGITS - 1)) w_seg_next = r_disp_sign ? 8'hFD : 8'hFF;
    if (r_disp_ovf) w_seg_next = 8'hFD;
  end

`ifdef SEG_BRIGHTNESS_EN
  assign w_lit = (32'(w_tick_next) <
                  ((32'(bus.BRIGHTNESS) + 32'd1) * 32'(TICKS_PER_DIGIT)) / 32'd8);
`else
  assign w_lit = 1'b1;
`endif
  assign w_an_next = w_lit ? ~(NUM_DIGITS'(1) << w_idx_next) : '1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_tick <= '0;
      r_idx  <= '0;
      r_seg  <= 8'hFF;
      r_an   <= '1;
    end else begin
      r_tick <= w_tick_next;
      r_idx  <= w_idx_next;
      r_seg  <= w_seg_next;
      r_an   <= w_an_next;
    end
  end

  assign bus.VALUE_READY = r_ready;
  assign bus.OVERFLOW    = r_disp_ovf;
  assign bus.segment     = r_seg;
  assign bus.anode       = r_an;
endmodule
`default_nettype wire

// File: tb/tb_signed_seg_display_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_signed_seg_display_ctrl : vector table plus reset / busy-valid sequences|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_signed_seg_display_ctrl;
  localparam int W  = 25;
  localparam int ND = 8;
  localparam int T  = 4;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  signed_seg_display_ctrl_if #(.INPUT_W(W), .NUM_DIGITS(ND)) bus ();

  signed_seg_display_ctrl #(.INPUT_W(W), .NUM_DIGITS(ND), .TICKS_PER_DIGIT(T)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct packed {
    logic [W-1:0]    val;
    logic            dp_en;
    logic [2:0]      dp_pos;
    logic            ovf;
    logic [ND*8-1:0] dig;   // {digit7 .. digit0}
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[9];

  function automatic vec_t mk(input int v, input logic en, input logic [2:0] pos,
                              input logic ovf, input logic [63:0] dig);
    vec_t r;
    logic [31:0] vv;
    vv       = v;
    r.val    = vv[W-1:0];
    r.dp_en  = en;
    r.dp_pos = pos;
    r.ovf    = ovf;
    r.dig    = dig;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Waits for READY, transfers one value, returns the READY-low cycle count
  task automatic send(input logic [W-1:0] v, input logic en, input logic [2:0] pos,
                      output int busy);
    int n;
    n = 0;
    while (!bus.VALUE_READY && n < 200) begin @(negedge CLK); n++; end
    chk("ready_before_send", {31'd0, bus.VALUE_READY}, 32'd1);
    bus.VALUE_IN = v; bus.DP_EN = en; bus.DP_POS = pos; bus.VALUE_VALID = 1'b1;
    @(negedge CLK);
    bus.VALUE_VALID = 1'b0;
    busy = 0;
    while (!bus.VALUE_READY && busy < 100) begin busy++; @(negedge CLK); end
  endtask

  task automatic scan(input string nm, input logic [63:0] exp);
    logic [7:0]    got[ND];
    logic [ND-1:0] prev;
    for (int d = 0; d < ND; d++) got[d] = 8'hxx;
    prev = bus.anode;
    for (int c = 0; c < 3 * ND * T; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++)
        if (bus.anode == ~(ND'(1) << d)) got[d] = bus.segment;
      if (bus.anode != prev) begin
        chk({nm, "_walk"}, {24'd0, bus.anode}, {24'd0, prev[ND-2:0], prev[ND-1]});
        prev = bus.anode;
      end
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("%s_d%0d", nm, d), {24'd0, got[d]}, {24'd0, exp[8*d +: 8]});
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_seg"},   {24'd0, bus.segment}, 32'hFF);
    chk({nm, "_anode"}, {24'd0, bus.anode},   32'hFF);
    chk({nm, "_ready"}, {31'd0, bus.VALUE_READY}, 32'd0);
    chk({nm, "_ovf"},   {31'd0, bus.OVERFLOW},    32'd0);
  endtask

  initial begin
    int busy;
    int n;
    bus.VALUE_IN = '0; bus.DP_EN = 1'b0; bus.DP_POS = '0; bus.VALUE_VALID = 1'b0;
`ifdef SEG_BRIGHTNESS_EN
    bus.BRIGHTNESS = 3'd7;
`endif
    vecs[0] = mk(12345,     1'b0, 3'd0, 1'b0, 64'hFFFFFF9F250D9949);
    vecs[1] = mk(-1234,     1'b1, 3'd3, 1'b0, 64'hFDFFFFFF9E250D99);
    vecs[2] = mk(5,         1'b1, 3'd3, 1'b0, 64'hFFFFFFFF02030349);
    vecs[3] = mk(10000000,  1'b0, 3'd0, 1'b1, 64'hFDFDFDFDFDFDFDFD);
    vecs[4] = mk(-16777216, 1'b1, 3'd2, 1'b1, 64'hFDFDFDFDFDFDFDFD);
    vecs[5] = mk(0,         1'b0, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFF03);
    vecs[6] = mk(9999999,   1'b1, 3'd7, 1'b0, 64'hFF09090909090909);
    vecs[7] = mk(7,         1'b1, 3'd0, 1'b0, 64'hFFFFFFFFFFFFFF1F);
    vecs[8] = mk(-1,        1'b1, 3'd6, 1'b0, 64'hFD0203030303039F);

    repeat (3) begin @(negedge CLK); chk_reset_outputs("reset"); end
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", {31'd0, bus.VALUE_READY}, 32'd1);
    chk("anode_after_reset", {24'd0, bus.anode},   32'hFE);
    chk("seg_after_reset",   {24'd0, bus.segment}, 32'h03);
    scan("idle", 64'hFFFFFFFFFFFFFF03);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].val, vecs[i].dp_en, vecs[i].dp_pos, busy);
      chk($sformatf("v%0d_busy", i), busy, 32'd26);
      @(negedge CLK);
      chk($sformatf("v%0d_ovf", i), {31'd0, bus.OVERFLOW}, {31'd0, vecs[i].ovf});
      scan($sformatf("v%0d", i), vecs[i].dig);
    end

    // VALID pulsed while busy must neither queue nor extend the conversion
    bus.VALUE_IN = 25'd42; bus.DP_EN = 1'b0; bus.DP_POS = '0; bus.VALUE_VALID = 1'b1;
    @(negedge CLK);
    bus.VALUE_VALID = 1'b0;
    n = 0;
    while (!bus.VALUE_READY && n < 100) begin
      n++;
      bus.VALUE_VALID = (n == 5);
      if (n == 5) bus.VALUE_IN = 25'd999;
      @(negedge CLK);
    end
    bus.VALUE_VALID = 1'b0;
    chk("ignore_busy", n, 32'd26);
    scan("ignore", 64'hFFFFFFFFFFFF9925);
    chk("ignore_ready_idle", {31'd0, bus.VALUE_READY}, 32'd1);

    // Reset in the middle of converting 777 discards it
    bus.VALUE_IN = 25'd777; bus.VALUE_VALID = 1'b1;
    @(negedge CLK);
    bus.VALUE_VALID = 1'b0;
    for (int c = 1; c < 10; c++) begin
      bus.VALUE_VALID = (c == 5);
      @(negedge CLK);
    end
    bus.VALUE_VALID = 1'b0;
    chk("midconv_busy", {31'd0, bus.VALUE_READY}, 32'd0);
    RESET_N = 1'b0;
    repeat (2) begin @(negedge CLK); chk_reset_outputs("midreset"); end
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("midreset_ready", {31'd0, bus.VALUE_READY}, 32'd1);
    repeat (30) @(negedge CLK);
    chk("midreset_ready_hold", {31'd0, bus.VALUE_READY}, 32'd1);
    chk("midreset_ovf", {31'd0, bus.OVERFLOW}, 32'd0);
    scan("midreset", 64'hFFFFFFFFFFFFFF03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
